// File: rtl/hazard_pkg.sv
// Shared types for the forwarding/stall controller: register address width,
// FSM state encoding and the per-stage tracking entry.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BUBBLE  = 2'd1,
    RECOVER = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              lui;
    logic              ld;
  } hz_entry_t;

  localparam hz_entry_t HZ_EMPTY = '0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle into the hazard controller and its forwarding/stall
// results. The master is the pipeline, the slave is hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import hazard_pkg::*;

  // id_valid qualifies every id_* field in the same cycle; stall is the only
  // back-pressure: while it is high the decode slot is held and not consumed.
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_is_lui;
  logic              id_is_load;
  logic              flush;

  logic              ALU1Ahz;
  logic              ALU1Bhz;
  logic              ALU2Ahz;
  logic              ALU2Bhz;
  logic              RAhz;
  logic              RBhz;
  logic              luiHaz1;
  logic              luiHaz2;
  logic              nop;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  hz_state_e         dbg_state;
  hz_entry_t         dbg_s1;
  hz_entry_t         dbg_s2;
  hz_entry_t         dbg_s3;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_lui, id_is_load, flush,
    input  ALU1Ahz, ALU1Bhz, ALU2Ahz, ALU2Bhz, RAhz, RBhz, luiHaz1, luiHaz2,
           nop, stall, stall_cnt, fwd_cnt, dbg_state, dbg_s1, dbg_s2, dbg_s3
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_is_lui, id_is_load, flush,
    output ALU1Ahz, ALU1Bhz, ALU2Ahz, ALU2Bhz, RAhz, RBhz, luiHaz1, luiHaz2,
           nop, stall, stall_cnt, fwd_cnt, dbg_state, dbg_s1, dbg_s2, dbg_s3
  );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// haz_cmp: matches one tracking entry against one decode source operand.
// x0 is never live, so it can never produce a match.
module haz_cmp
  import hazard_pkg::*;
(
  input  logic              v_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              wr_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              use_i,
  output logic              match_o,
  output logic              live_o
);

  assign live_o  = v_i & wr_i & (|rd_i);
  assign match_o = live_o & use_i & (rd_i == rs_i);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding match detection for EX/MEM/WB and load-use bubble
// control. Define HAZ_PERF_EN to build the stall/forward performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  hz_entry_t s1_q, s2_q, s3_q;
  hz_entry_t s1_d;
  hz_entry_t stg [3];

  logic [2:0] m_a, m_b;
  logic [2:0] live_a, live_b;
  logic [2:0] live;
  logic       luse;
  logic       stall;

  hz_state_e  state_q;
  hz_state_e  cur_state;

  assign stg[0] = s1_q;
  assign stg[1] = s2_q;
  assign stg[2] = s3_q;

  for (genvar g = 0; g < 3; g++) begin : g_cmp
    haz_cmp u_cmp_a (
      .v_i     (stg[g].v),
      .rd_i    (stg[g].rd),
      .wr_i    (stg[g].wr),
      .rs_i    (hz.id_rs1),
      .use_i   (hz.id_use_rs1),
      .match_o (m_a[g]),
      .live_o  (live_a[g])
    );
    haz_cmp u_cmp_b (
      .v_i     (stg[g].v),
      .rd_i    (stg[g].rd),
      .wr_i    (stg[g].wr),
      .rs_i    (hz.id_rs2),
      .use_i   (hz.id_use_rs2),
      .match_o (m_b[g]),
      .live_o  (live_b[g])
    );
  end

  assign live = live_a | live_b;

  assign hz.ALU1Ahz = m_a[0];
  assign hz.ALU1Bhz = m_b[0];
  assign hz.ALU2Ahz = m_a[1];
  assign hz.ALU2Bhz = m_b[1];
  assign hz.RAhz    = m_a[2];
  assign hz.RBhz    = m_b[2];
  assign hz.luiHaz1 = live[0] & s1_q.lui;
  assign hz.luiHaz2 = live[1] & s2_q.lui;

  assign luse = live[0] & s1_q.ld & (m_a[0] | m_b[0]) & hz.id_valid;

  // state_q is the state the cycle starts in; a load-use seen in RUN turns
  // this very cycle into BUBBLE so the bubble lands with zero latency.
  always_comb begin
    cur_state = state_q;
    if (state_q == RUN && luse) begin
      cur_state = BUBBLE;
    end
  end

  assign stall    = (cur_state == BUBBLE);
  assign hz.stall = stall;
  assign hz.nop   = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      case (cur_state)
        BUBBLE:  state_q <= RECOVER;
        RECOVER: state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_comb begin
    s1_d = HZ_EMPTY;
    if (hz.id_valid && !hz.flush && !stall) begin
      s1_d.v   = 1'b1;
      s1_d.rd  = hz.id_rd;
      s1_d.wr  = hz.id_regwrite;
      s1_d.lui = hz.id_is_lui;
      s1_d.ld  = hz.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= HZ_EMPTY;
      s2_q <= HZ_EMPTY;
      s3_q <= HZ_EMPTY;
    end else begin
      s1_q <= s1_d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign hz.dbg_state = cur_state;
  assign hz.dbg_s1    = s1_q;
  assign hz.dbg_s2    = s2_q;
  assign hz.dbg_s3    = s3_q;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [1:0]       fwd_inc;

  // Operands consumed during the bubble are re-presented next cycle, so
  // they are only counted outside BUBBLE.
  always_comb begin
    fwd_inc = 2'd0;
    if (cur_state != BUBBLE && hz.id_valid) begin
      fwd_inc = {1'b0, |m_a} + {1'b0, |m_b};
    end
    fwd_cnt_d   = fwd_cnt_q + CNT_W'(fwd_inc);
    stall_cnt_d = stall_cnt_q + CNT_W'(stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.fwd_cnt   = fwd_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.fwd_cnt   = '0;
`endif

endmodule
